// File: rtl/set_job_sched.sv
// Round-robin front end that time-shares one SET point-count engine between NREQ requesters.
// It parks the engine in reset between jobs and returns each count (or a timeout) to its owner.
module set_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int MIN_LAT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [24*NREQ-1:0] req_central,
  input  logic [12*NREQ-1:0] req_radius,
  input  logic [2*NREQ-1:0]  req_mode,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic [7:0]         result,
  output logic               err,
  output logic               busy,
  output logic               eng_rst,
  output logic               eng_en,
  output logic [23:0]        eng_central,
  output logic [11:0]        eng_radius,
  output logic [1:0]         eng_mode,
  input  logic               eng_valid,
  input  logic [7:0]         eng_candidate,
  output logic               dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   done_q;
  logic [7:0]        result_q;
  logic              err_q;
  logic              busy_q;
  logic              eng_rst_q;
  logic              eng_en_q;
  logic [23:0]       eng_central_q;
  logic [11:0]       eng_radius_q;
  logic [1:0]        eng_mode_q;

  logic              gnt_found_d;
  logic [IW-1:0]     gnt_idx_d;
  logic [23:0]       sel_central_d;
  logic [11:0]       sel_radius_d;
  logic [1:0]        sel_mode_d;
  logic              complete_d;
  logic              timeout_d;

  // Search starts one past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    int idx;
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found_d && req[idx]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_central_d = '0;
    sel_radius_d  = '0;
    sel_mode_d    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_d == IW'(i)) begin
        sel_central_d = req_central[24*i +: 24];
        sel_radius_d  = req_radius[12*i +: 12];
        sel_mode_d    = req_mode[2*i +: 2];
      end
    end
  end

  // The count gate is evaluated first so a stale or X valid during the blind window is masked.
  // The abort fires when cnt reaches TIMEOUT, landing done TIMEOUT+1 cycles after ack.
  always_comb begin
    complete_d = (cnt_q >= CW'(MIN_LAT)) && eng_valid;
    timeout_d  = (cnt_q == CW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(NREQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      eng_rst_q     <= 1'b1;
      eng_en_q      <= 1'b0;
      eng_central_q <= '0;
      eng_radius_q  <= '0;
      eng_mode_q    <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found_d) begin
            ptr_q         <= gnt_idx_d;
            owner_q       <= gnt_idx_d;
            eng_central_q <= sel_central_d;
            eng_radius_q  <= sel_radius_d;
            eng_mode_q    <= sel_mode_d;
            ack_q         <= NREQ'(1) << gnt_idx_d;
            cnt_q         <= '0;
            eng_rst_q     <= 1'b0;
            eng_en_q      <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_RUN;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (complete_d || timeout_d) begin
            result_q  <= complete_d ? eng_candidate : 8'd0;
            err_q     <= !complete_d;
            done_q    <= NREQ'(1) << owner_q;
            eng_rst_q <= 1'b1;
            eng_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign result      = result_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign eng_rst     = eng_rst_q;
  assign eng_en      = eng_en_q;
  assign eng_central = eng_central_q;
  assign eng_radius  = eng_radius_q;
  assign eng_mode    = eng_mode_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_set_job_sched.sv
// Bench for set_job_sched: table of single jobs against a behavioural engine, plus
// hand-written round-robin, mid-job reset and held-request sequences.
module tb_set_job_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 1023;
  localparam int MIN_LAT = 16;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [24*NREQ-1:0] req_central;
  logic [12*NREQ-1:0] req_radius;
  logic [2*NREQ-1:0]  req_mode;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [7:0]         result;
  logic               err;
  logic               busy;
  logic               eng_rst;
  logic               eng_en;
  logic [23:0]        eng_central;
  logic [11:0]        eng_radius;
  logic [1:0]         eng_mode;
  logic               eng_valid;
  logic [7:0]         eng_candidate;
  logic               dbg_state;

  set_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MIN_LAT(MIN_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_central(req_central),
    .req_radius(req_radius), .req_mode(req_mode), .ack(ack), .done(done),
    .result(result), .err(err), .busy(busy), .eng_rst(eng_rst), .eng_en(eng_en),
    .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
    .eng_valid(eng_valid), .eng_candidate(eng_candidate), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Engine model: run_cyc is 0 in the ack cycle; valid pulses at m_lat and m_stale.
  int       m_lat   = -1;
  int       m_stale = -1;
  logic [7:0] m_cand = '0;
  int       run_cyc = 0;
  bit       in_run  = 0;

  initial begin
    eng_valid     = 1'b0;
    eng_candidate = '0;
    forever begin
      @(posedge clk);
      #1;
      if (eng_rst !== 1'b0) begin
        in_run  = 0;
        run_cyc = 0;
      end else begin
        run_cyc = in_run ? run_cyc + 1 : 0;
        in_run  = 1;
      end
      eng_valid     = in_run && (run_cyc == m_lat || run_cyc == m_stale);
      eng_candidate = m_cand;
    end
  end

  // scoreboard
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // driver tasks
  task automatic set_slot(input int i, input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] m);
    req_central[24*i +: 24] = c;
    req_radius[12*i +: 12]  = r;
    req_mode[2*i +: 2]      = m;
  endtask

  task automatic wait_ack(input int bound, output logic [NREQ-1:0] bits, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < bound);
    bits = ack;
  endtask

  task automatic wait_done(input int bound, input logic [23:0] rc, input logic [11:0] rr,
                           input logic [1:0] rm, output logic [NREQ-1:0] bits,
                           output int n, output bit stable);
    n = 0;
    stable = 1;
    do begin
      @(negedge clk);
      n++;
      if (done == '0 && (eng_central !== rc || eng_radius !== rr || eng_mode !== rm ||
                         eng_en !== 1'b1 || eng_rst !== 1'b0)) stable = 0;
    end while (done == '0 && n < bound);
    bits = done;
  endtask

  typedef struct {
    int         idx;
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    int         lat;
    int         stale;
    logic [7:0] cand;
    logic [7:0] exp_res;
    logic       exp_err;
    int         exp_gap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NREQ-1:0] bits;
    logic [NREQ-1:0] exp_bits;
    int   n;
    bit   stable;
    int   rr_order[4];
    int   done_seen;

    vecs[0] = '{2, 24'h448800, 12'h222, 2'd0,  800, -1, 8'd13,  8'd13,  1'b0,  801};
    vecs[1] = '{0, 24'h123456, 12'h345, 2'd1,   -1, -1, 8'hAA,  8'd0,   1'b1, 1024};
    vecs[2] = '{3, 24'hABCDEF, 12'h789, 2'd2,  800,  3, 8'd7,   8'd7,   1'b0,  801};
    vecs[3] = '{1, 24'h0F0F0F, 12'hFFF, 2'd3,   16, -1, 8'd255, 8'd255, 1'b0,   17};
    vecs[4] = '{2, 24'h000001, 12'h001, 2'd1,   20, 15, 8'd42,  8'd42,  1'b0,   21};
    vecs[5] = '{0, 24'h765432, 12'h0A5, 2'd2, 1023, -1, 8'd99,  8'd99,  1'b0, 1024};
    rr_order = '{0, 3, 0, 3};

    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++)
      set_slot(i, 24'($urandom), 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
    repeat (3) @(negedge clk);

    chk("reset ack", ack, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset err", err, 0);
    chk("reset busy", busy, 0);
    chk("reset eng_rst", eng_rst, 1);
    chk("reset eng_en", eng_en, 0);
    chk("reset eng_central", eng_central, 0);
    chk("reset eng_radius", eng_radius, 0);
    chk("reset eng_mode", eng_mode, 0);
    chk("reset state", dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);

    // Round robin: requesters 0 and 3 re-request after each done.
    m_lat = 40; m_stale = -1; m_cand = 8'd5;
    set_slot(0, 24'h111111, 12'h111, 2'd1);
    set_slot(3, 24'h333333, 12'h333, 2'd3);
    req = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      wait_ack(5, bits, n);
      exp_bits = NREQ'(1) << rr_order[j];
      chk($sformatf("rr ack order %0d", j), bits, exp_bits);
      chk($sformatf("rr ack latency %0d", j), n, 1);
      req = req & ~bits;
      wait_done(200, eng_central, eng_radius, eng_mode, bits, n, stable);
      chk($sformatf("rr done %0d", j), bits, exp_bits);
      chk($sformatf("rr eng_rst in done %0d", j), eng_rst, 1);
      chk($sformatf("rr result %0d", j), result, 5);
      if (j < 3) req = req | bits;
    end
    req = '0;
    @(negedge clk);

    // Table of single jobs.
    for (int v = 0; v < 6; v++) begin
      m_lat = vecs[v].lat; m_stale = vecs[v].stale; m_cand = vecs[v].cand;
      for (int i = 0; i < NREQ; i++)
        if (i != vecs[v].idx) set_slot(i, 24'($urandom), 12'($urandom_range(0, 4095)), 2'd3);
      set_slot(vecs[v].idx, vecs[v].c, vecs[v].r, vecs[v].m);
      req = NREQ'(1) << vecs[v].idx;
      exp_bits = req;
      wait_ack(5, bits, n);
      chk($sformatf("v%0d ack", v), bits, exp_bits);
      chk($sformatf("v%0d ack latency", v), n, 1);
      chk($sformatf("v%0d busy in run", v), busy, 1);
      chk($sformatf("v%0d eng_central", v), eng_central, vecs[v].c);
      chk($sformatf("v%0d eng_radius", v), eng_radius, vecs[v].r);
      chk($sformatf("v%0d eng_mode", v), eng_mode, vecs[v].m);
      req = '0;
      wait_done(TIMEOUT + 20, vecs[v].c, vecs[v].r, vecs[v].m, bits, n, stable);
      chk($sformatf("v%0d operands stable", v), stable, 1);
      chk($sformatf("v%0d done", v), bits, exp_bits);
      chk($sformatf("v%0d ack-to-done cycles", v), n, vecs[v].exp_gap);
      chk($sformatf("v%0d result", v), result, vecs[v].exp_res);
      chk($sformatf("v%0d err", v), err, vecs[v].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d done pulse width", v), done, 0);
      chk($sformatf("v%0d busy after", v), busy, 0);
      chk($sformatf("v%0d result hold", v), result, vecs[v].exp_res);
      chk($sformatf("v%0d err hold", v), err, vecs[v].exp_err);
    end

    // Reset mid-job at RUN cycle 300; ptr returns to NREQ-1.
    m_lat = 800; m_stale = -1; m_cand = 8'd77;
    set_slot(2, 24'h222222, 12'h222, 2'd2);
    req = 4'b0100;
    wait_ack(5, bits, n);
    chk("mid ack", bits, 4'b0100);
    req = '0;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid result", result, 0);
    chk("mid err", err, 0);
    chk("mid busy", busy, 0);
    chk("mid eng_rst", eng_rst, 1);
    chk("mid eng_en", eng_en, 0);
    chk("mid eng_central", eng_central, 0);
    chk("mid eng_radius", eng_radius, 0);
    chk("mid eng_mode", eng_mode, 0);
    chk("mid ack after reset", ack, 0);
    done_seen = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done != '0) done_seen++;
    end
    chk("mid no done", done_seen, 0);
    m_lat = 50; m_cand = 8'd21;
    set_slot(1, 24'h010101, 12'h010, 2'd1);
    req = 4'b0110;
    wait_ack(5, bits, n);
    chk("post-reset grant", bits, 4'b0010);
    req = '0;
    wait_done(200, 24'h010101, 12'h010, 2'd1, bits, n, stable);
    chk("post-reset done", bits, 4'b0010);
    chk("post-reset result", result, 21);
    @(negedge clk);

    // Held request: requester 1 keeps req high across its own done.
    m_lat = 100; m_cand = 8'd3;
    set_slot(1, 24'hA1A1A1, 12'hA1A, 2'd2);
    req = 4'b0010;
    wait_ack(5, bits, n);
    chk("held ack1", bits, 4'b0010);
    set_slot(1, 24'hB2B2B2, 12'hB2B, 2'd1);
    wait_done(300, 24'hA1A1A1, 12'hA1A, 2'd2, bits, n, stable);
    chk("held job1 stable", stable, 1);
    chk("held done1", bits, 4'b0010);
    wait_ack(5, bits, n);
    chk("held ack2", bits, 4'b0010);
    chk("held done-to-ack", n, 1);
    chk("held recapture central", eng_central, 24'hB2B2B2);
    chk("held recapture radius", eng_radius, 12'hB2B);
    req = '0;
    wait_done(300, 24'hB2B2B2, 12'hB2B, 2'd1, bits, n, stable);
    chk("held done2", bits, 4'b0010);
    chk("held result2", result, 3);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
